// File: rtl/add_top.sv
// Ripple-carry two's-complement adder with carry-in, signed overflow and carry-out.
// Combinational result path plus a one-cycle registered copy for pipelined consumers.
module add_top #(
   parameter int unsigned WIDTH = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cin,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] out,
   output logic             overflow,
   output logic             cout,
   output logic [WIDTH-1:0] out_q,
   output logic             overflow_q,
   output logic             cout_q
);

   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum;

   // Full-adder chain; carry[i] enters bit i, carry[WIDTH] leaves the MSB.
   always_comb begin
      carry    = '0;
      sum      = '0;
      carry[0] = cin;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         sum[i]     = a[i] ^ b[i] ^ carry[i];
         carry[i+1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & carry[i]);
      end
   end

   // Signed overflow: carry into the sign bit differs from carry out of it.
   assign out      = sum;
   assign cout     = carry[WIDTH];
   assign overflow = carry[WIDTH] ^ carry[WIDTH-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q      <= '0;
         overflow_q <= 1'b0;
         cout_q     <= 1'b0;
      end else begin
         out_q      <= out;
         overflow_q <= overflow;
         cout_q     <= cout;
      end
   end

endmodule

// File: tb/tb_add_top.sv
// Scoreboard bench for add_top: exhaustive combinational sweep, boundary and
// subtraction cases, registered path latency and asynchronous reset behaviour.
module tb_add_top;

   localparam int unsigned WIDTH = 6;

   typedef struct packed {
      logic [WIDTH-1:0] out;
      logic             ovf;
      logic             cout;
   } res_t;

   logic             clk;
   logic             rst_n;
   logic             cin;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] out;
   logic             overflow;
   logic             cout;
   logic [WIDTH-1:0] out_q;
   logic             overflow_q;
   logic             cout_q;

   int   n_cmp;
   int   n_err;
   res_t comb_q[$];
   res_t reg_q[$];

   add_top #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cin        (cin),
      .a          (a),
      .b          (b),
      .out        (out),
      .overflow   (overflow),
      .cout       (cout),
      .out_q      (out_q),
      .overflow_q (overflow_q),
      .cout_q     (cout_q)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Integer reference: signed sum for out/overflow, unsigned sum for carry-out.
   function automatic res_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                  input logic ci);
      res_t r;
      int   s;
      int   u;
      s      = int'($signed(x)) + int'($signed(y)) + int'(ci);
      u      = int'(x) + int'(y) + int'(ci);
      r.out  = WIDTH'(s);
      r.ovf  = (s < -32) || (s > 31);
      r.cout = u[WIDTH];
      return r;
   endfunction

   task automatic drive(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic ci);
      a   = x;
      b   = y;
      cin = ci;
   endtask

   // Pop the expected combinational result once the inputs have had 10 units to settle.
   task automatic settle_and_compare(input string tag, input logic chk_cout);
      res_t e;
      #10;
      if (comb_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s: comb scoreboard empty", tag);
      end else begin
         e = comb_q.pop_front();
         check({tag, "_out"}, 32'(out), 32'(e.out));
         check({tag, "_ovf"}, 32'(overflow), 32'(e.ovf));
         if (chk_cout) check({tag, "_cout"}, 32'(cout), 32'(e.cout));
      end
   endtask

   task automatic compare_reg(input string tag);
      res_t e;
      if (reg_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s: reg scoreboard empty", tag);
      end else begin
         e = reg_q.pop_front();
         check({tag, "_out_q"}, 32'(out_q), 32'(e.out));
         check({tag, "_ovf_q"}, 32'(overflow_q), 32'(e.ovf));
         check({tag, "_cout_q"}, 32'(cout_q), 32'(e.cout));
      end
   endtask

   typedef struct {
      string            name;
      logic [WIDTH-1:0] x;
      logic [WIDTH-1:0] y;
      logic             ci;
      logic [WIDTH-1:0] eout;
      logic             eovf;
      logic             ecout;
   } vec_t;

   vec_t vecs[6];

   initial begin
      n_cmp = 0;
      n_err = 0;
      vecs[0] = '{"max_plus_one", 6'd31, 6'd1,  1'b0, 6'b100000, 1'b1, 1'b0};
      vecs[1] = '{"min_minus_one", 6'b100000, 6'b111111, 1'b0, 6'd31, 1'b1, 1'b1};
      vecs[2] = '{"min_plus_max", 6'b100000, 6'd31, 1'b0, 6'b111111, 1'b0, 1'b0};
      vecs[3] = '{"neg1_neg1", 6'b111111, 6'b111111, 1'b0, 6'b111110, 1'b0, 1'b1};
      vecs[4] = '{"sub_10_3", 6'd10, ~6'd3, 1'b1, 6'd7, 1'b0, 1'b1};
      vecs[5] = '{"sub_min_1", 6'b100000, ~6'd1, 1'b1, 6'd31, 1'b1, 1'b1};

      // Reset state; combinational path still tracks inputs during reset.
      rst_n = 1'b0;
      drive(6'd3, 6'd4, 1'b0);
      comb_q.push_back(model(6'd3, 6'd4, 1'b0));
      #3;
      check("rst_out_q", 32'(out_q), 32'd0);
      check("rst_ovf_q", 32'(overflow_q), 32'd0);
      check("rst_cout_q", 32'(cout_q), 32'd0);
      settle_and_compare("rst_comb", 1'b1);
      @(posedge clk);
      #1;
      check("rst_hold_out_q", 32'(out_q), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Exhaustive signed sweep with cin=0.
      for (int i = -32; i < 32; i++) begin
         for (int j = -32; j < 32; j++) begin
            drive(WIDTH'(i), WIDTH'(j), 1'b0);
            comb_q.push_back(model(WIDTH'(i), WIDTH'(j), 1'b0));
            settle_and_compare($sformatf("sweep_a%0d_b%0d", i, j), 1'b1);
         end
      end

      // Random cin=1 coverage.
      for (int k = 0; k < 200; k++) begin
         logic [WIDTH-1:0] x;
         logic [WIDTH-1:0] y;
         x = WIDTH'($urandom_range(63, 0));
         y = WIDTH'($urandom_range(63, 0));
         drive(x, y, 1'b1);
         comb_q.push_back(model(x, y, 1'b1));
         settle_and_compare($sformatf("cin1_a%0h_b%0h", x, y), 1'b1);
      end

      // Boundary and subtraction vectors against fixed expectations.
      foreach (vecs[v]) begin
         drive(vecs[v].x, vecs[v].y, vecs[v].ci);
         comb_q.push_back('{vecs[v].eout, vecs[v].eovf, vecs[v].ecout});
         settle_and_compare(vecs[v].name, 1'b1);
      end

      // Registered path: one cycle of latency.
      @(negedge clk);
      drive(6'd5, 6'd7, 1'b0);
      reg_q.push_back('{6'd12, 1'b0, 1'b0});
      @(posedge clk);
      #1;
      compare_reg("reg_5_7");
      @(negedge clk);
      drive(6'd31, 6'd1, 1'b0);
      #2;
      check("reg_hold_out_q", 32'(out_q), 32'd12);
      reg_q.push_back('{6'b100000, 1'b1, 1'b0});
      @(posedge clk);
      #1;
      compare_reg("reg_31_1");

      // Asynchronous reset pulse between edges.
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_out_q", 32'(out_q), 32'd0);
      check("arst_ovf_q", 32'(overflow_q), 32'd0);
      check("arst_cout_q", 32'(cout_q), 32'd0);
      check("arst_comb_out", 32'(out), 32'h20);
      check("arst_comb_ovf", 32'(overflow), 32'd1);
      #3;
      rst_n = 1'b1;
      #1;
      check("arst_rel_out_q", 32'(out_q), 32'd0);
      reg_q.push_back('{6'b100000, 1'b1, 1'b0});
      @(posedge clk);
      #1;
      compare_reg("arst_reload");

      // Carry-out through the registered path.
      @(negedge clk);
      drive(6'b111111, 6'b111111, 1'b0);
      reg_q.push_back(model(6'b111111, 6'b111111, 1'b0));
      @(posedge clk);
      #1;
      compare_reg("reg_neg1_neg1");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/add_top.md
Name: add_top

Overview:
- 6-bit two's-complement adder with carry-in, signed-overflow flag and carry-out.
- Primary result path is purely combinational; `out` and `overflow` settle within one propagation delay of any input change.
- A registered copy of the result is provided for pipelined consumers.
- Serves as the ADD/SUB datapath slice of the ALU. For SUB, the caller inverts `b` and drives `cin`=1.

Parameters:
- WIDTH, 6, operand/result width in bits (signed range -(2^(WIDTH-1)) .. 2^(WIDTH-1)-1, i.e. -32..31 at default).

Ports:
- clk  input  1  rising-edge clock for the registered outputs only
- rst_n  input  1  asynchronous active-low reset; clears registered outputs
- cin  input  1  carry-in (0 for ADD, 1 for SUB with inverted b)
- a  input  WIDTH  signed operand A
- b  input  WIDTH  signed operand B
- out  output  WIDTH  signed sum a+b+cin, truncated to WIDTH bits (combinational)
- overflow  output  1  signed overflow of out (combinational)
- cout  output  1  unsigned carry out of MSB (combinational)
- out_q  output  WIDTH  registered out
- overflow_q  output  1  registered overflow
- cout_q  output  1  registered cout

Behaviour:
- Structure: ripple-carry chain of WIDTH full-adder cells.
  - Bit 0 carry-in is `cin`.
  - c[i+1] = a[i]&b[i] | (a[i]^b[i])&c[i].
  - s[i] = a[i]^b[i]^c[i].
- out = s[WIDTH-1:0], i.e. (a + b + cin) mod 2^WIDTH, interpreted as signed.
- cout = c[WIDTH].
- overflow = c[WIDTH] XOR c[WIDTH-1]. Equivalently, overflow is 1 iff the true integer a+b+cin lies outside -32..31.
- When overflow=1, out still holds the wrapped WIDTH-bit result. No saturation.
- When overflow=0, out equals the exact integer a+b+cin.
- Combinational outputs:
  - Depend only on a, b, cin.
  - Independent of clk and rst_n.
  - No latches; they must be valid 10 time units after any input change.
- Registered outputs:
  - On each rising clk edge with rst_n=1: out_q<=out, overflow_q<=overflow, cout_q<=cout.
  - Latency 1 cycle relative to the combinational path.
- Reset:
  - rst_n low immediately (asynchronously) forces out_q=0, overflow_q=0, cout_q=0.
  - The registered outputs hold those values while rst_n is low.
  - Reset asserted mid-operation discards the pending registered value.
  - Combinational outputs keep tracking their inputs during reset.
- First rising edge after rst_n deasserts captures the current combinational result.
- No X propagation for any of the 2·64·64 input combinations.

Test Plan:
- Exhaustive sweep, cin=0, a and b each over -32..31 (4096 cases), checked 10 time units after each change:
  - If -32 ≤ a+b ≤ 31: overflow=0 and out=a+b.
  - Otherwise: overflow=1.
- Boundary cases, cin=0:
  - a=31, b=1 -> out=-32 (6'b100000), overflow=1, cout=0.
  - a=-32, b=-1 -> out=31, overflow=1, cout=1.
  - a=-32, b=31 -> out=-1, overflow=0.
  - a=-1, b=-1 -> out=-2, overflow=0, cout=1.
- Subtraction via cin:
  - cin=1, a=10, b=~3 (=-4) -> out=7, overflow=0.
  - cin=1, a=-32, b=~1 (=-2) -> out=31, overflow=1.
- Registered path:
  - Apply a=5, b=7, cin=0 and clock once -> out_q=12, overflow_q=0, cout_q=0.
  - Change inputs to a=31, b=1 -> out_q unchanged until the next edge, then out_q=-32, overflow_q=1.
- Reset:
  - Pulse rst_n low between clock edges while out_q=-32 -> out_q, overflow_q, cout_q go to 0 immediately, without a clock edge.
  - out and overflow are unaffected throughout.
  - After release, the first edge reloads out_q.
